// File: rtl/program_ram.sv
// Program memory for exec_unit: registered CPU read/write port plus a byte-serial
// program-load port that holds the CPU off the bus while a load is running.
`ifndef MEMORY_ADDRESS_BITS
`define MEMORY_ADDRESS_BITS 8
`endif
`ifndef MEMORY_DATA_BITS
`define MEMORY_DATA_BITS 8
`endif

module program_ram #(
  parameter int ADDR_BITS = `MEMORY_ADDRESS_BITS,
  parameter int DATA_BITS = `MEMORY_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 load_done,
  output logic                 cpu_hold
);

  typedef enum logic [1:0] {
    SERVE,
    LOAD,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] load_addr_q, load_addr_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_waddr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // The array is read before this edge's write lands, which gives read-first behaviour.
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    rd_data_d   = rd_data_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    case (state_q)
      SERVE: begin
        if (rd_en) rd_data_d = mem[rd_addr];
        if (wr_en) mem_we = 1'b1;
        if (load_start) begin
          state_d     = LOAD;
          load_addr_d = '0;
        end
      end
      LOAD: begin
        rd_data_d = '0;
        if (load_valid) begin
          mem_we      = 1'b1;
          mem_waddr   = load_addr_q;
          mem_wdata   = load_data;
          load_addr_d = load_addr_q + ADDR_BITS'(1);
          if (load_last) state_d = DONE;
        end
        if (load_start) load_addr_d = '0;
      end
      DONE: begin
        state_d = SERVE;
      end
      default: begin
        state_d = SERVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SERVE;
      load_addr_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Contents survive reset so a partially loaded program is not lost.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_data    = rd_data_q;
  assign load_ready = (state_q == LOAD);
  assign load_done  = (state_q == DONE);
  assign cpu_hold   = (state_q != SERVE);

endmodule

// File: tb/tb_program_ram.sv
// Self-checking bench for program_ram: directed scenarios plus randomized traffic
// compared against an array model of the memory.
module tb_program_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_last = 1'b0;
  logic       load_ready, load_done, cpu_hold;

  logic       s_rd_en = 1'b0;
  logic [1:0] s_rd_addr = '0;
  logic [7:0] s_rd_data;
  logic       s_wr_en = 1'b0;
  logic [1:0] s_wr_addr = '0;
  logic [7:0] s_wr_data = '0;
  logic       s_load_start = 1'b0;
  logic       s_load_valid = 1'b0;
  logic [7:0] s_load_data = '0;
  logic       s_load_last = 1'b0;
  logic       s_load_ready, s_load_done, s_cpu_hold;

  program_ram #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .cpu_hold(cpu_hold)
  );

  program_ram #(.ADDR_BITS(2), .DATA_BITS(8)) dut_small (
    .clk(clk), .reset(reset),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .load_start(s_load_start), .load_valid(s_load_valid), .load_data(s_load_data),
    .load_last(s_load_last), .load_ready(s_load_ready), .load_done(s_load_done),
    .cpu_hold(s_cpu_hold)
  );

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int s_done_count = 0;
  logic [7:0] model [256];
  logic [7:0] load_buf [64];

  always @(negedge clk) begin
    if (load_done === 1'b1) done_count++;
    if (s_load_done === 1'b1) s_done_count++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    rd_en = 0; wr_en = 0; load_start = 0; load_valid = 0; load_last = 0;
    s_rd_en = 0; s_wr_en = 0; s_load_start = 0; s_load_valid = 0; s_load_last = 0;
  endtask

  task automatic cpu_read(input logic [7:0] addr);
    rd_en = 1; rd_addr = addr;
    step;
    rd_en = 0;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [7:0] data);
    wr_en = 1; wr_addr = addr; wr_data = data;
    step;
    wr_en = 0;
    model[addr] = data;
  endtask

  // Load load_buf[0..n-1] from address 0; optionally with bubbles and CPU traffic.
  task automatic run_load(input int n, input bit bubbles, input bit cpu_noise);
    int base;
    base = done_count;
    load_start = 1;
    step;
    load_start = 0;
    checks++;
    if (load_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_entry: ready=%b hold=%b expected 1 1", load_ready, cpu_hold);
    end
    for (int i = 0; i < n; i++) begin
      if (cpu_noise) begin
        rd_en = 1; rd_addr = 8'h00; wr_en = 1; wr_addr = 8'h40; wr_data = 8'hFF;
      end
      if (bubbles && $urandom_range(0, 2) == 0) begin
        load_valid = 0; load_data = 8'($urandom);
        step;
        checks++;
        if (load_done !== 1'b0 || load_ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL load_bubble: done=%b ready=%b expected 0 1", load_done, load_ready);
        end
      end
      load_valid = 1; load_data = load_buf[i]; load_last = (i == n - 1);
      step;
      model[i % 256] = load_buf[i];
      if (cpu_noise) begin
        checks++;
        if (rd_data !== 8'h00) begin
          errors++;
          $display("[TB] FAIL load_rd_forced: rd_data=%h expected 00", rd_data);
        end
      end
    end
    clear_inputs;
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done_cycle: done=%b hold=%b ready=%b expected 1 1 0",
               load_done, cpu_hold, load_ready);
    end
    step;
    checks++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_release: done=%b hold=%b expected 0 0", load_done, cpu_hold);
    end
    checks++;
    if (done_count !== base + 1) begin
      errors++;
      $display("[TB] FAIL load_done_pulses: got %0d expected %0d", done_count - base, 1);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    clear_inputs;
    step;
    step;
    checks++;
    if (rd_data !== 8'h00 || load_ready !== 1'b0 || load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rd=%h ready=%b done=%b hold=%b expected 00 0 0 0",
               rd_data, load_ready, load_done, cpu_hold);
    end
    checks++;
    if (s_rd_data !== 8'h00 || s_load_ready !== 1'b0 || s_load_done !== 1'b0 || s_cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_small: rd=%h ready=%b done=%b hold=%b expected 00 0 0 0",
               s_rd_data, s_load_ready, s_load_done, s_cpu_hold);
    end
    reset = 0;
    step;
  endtask

  task automatic test_load_then_read;
    logic [7:0] words [8];
    words = '{8'h00, 8'h00, 8'h10, 8'h55, 8'h10, 8'hAA, 8'h10, 8'h11};
    for (int i = 0; i < 8; i++) load_buf[i] = words[i];
    run_load(8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cpu_read(8'(i));
      checks++;
      if (rd_data !== words[i]) begin
        errors++;
        $display("[TB] FAIL load_read[%0d]: got %h expected %h", i, rd_data, words[i]);
      end
    end
  endtask

  task automatic test_write_read;
    logic [7:0] exp;
    cpu_write(8'h20, 8'h3C);
    cpu_read(8'h20);
    checks++;
    if (rd_data !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL write_read: got %h expected 3c", rd_data);
    end
    exp = model[8'h20];
    rd_en = 1; rd_addr = 8'h20; wr_en = 1; wr_addr = 8'h20; wr_data = 8'h5A;
    step;
    rd_en = 0; wr_en = 0;
    model[8'h20] = 8'h5A;
    checks++;
    if (rd_data !== exp) begin
      errors++;
      $display("[TB] FAIL read_first: got %h expected %h", rd_data, exp);
    end
    cpu_read(8'h20);
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL read_after_write: got %h expected 5a", rd_data);
    end
    step;
    checks++;
    if (rd_data !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL rd_hold: got %h expected 5a", rd_data);
    end
  endtask

  task automatic test_cpu_blocked;
    logic [7:0] v;
    v = 8'($urandom_range(0, 254));
    cpu_write(8'h40, v);
    cpu_read(8'h20);
    for (int i = 0; i < 3; i++) load_buf[i] = 8'($urandom);
    run_load(3, 1'b1, 1'b1);
    cpu_read(8'h40);
    checks++;
    if (rd_data !== model[8'h40]) begin
      errors++;
      $display("[TB] FAIL blocked_write: got %h expected %h", rd_data, model[8'h40]);
    end
  endtask

  task automatic test_reset_mid_load;
    int base;
    base = done_count;
    load_start = 1;
    step;
    load_start = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = 8'($urandom); load_last = 0;
      step;
      model[i] = load_data;
    end
    load_valid = 0;
    reset = 1;
    step;
    checks++;
    if (rd_data !== 8'h00 || load_ready !== 1'b0 || load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_load: rd=%h ready=%b done=%b hold=%b expected 00 0 0 0",
               rd_data, load_ready, load_done, cpu_hold);
    end
    reset = 0;
    step;
    step;
    checks++;
    if (done_count !== base || cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done: pulses=%0d hold=%b expected 0 0", done_count - base, cpu_hold);
    end
    for (int i = 0; i < 3; i++) begin
      cpu_read(8'(i));
      checks++;
      if (rd_data !== model[i]) begin
        errors++;
        $display("[TB] FAIL reset_kept[%0d]: got %h expected %h", i, rd_data, model[i]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] sm [4];
    int base;
    base = s_done_count;
    s_load_start = 1;
    step;
    s_load_start = 0;
    for (int i = 0; i < 6; i++) begin
      s_load_valid = 1; s_load_data = 8'(i + 1); s_load_last = (i == 5);
      step;
      sm[i % 4] = 8'(i + 1);
    end
    clear_inputs;
    step;
    step;
    checks++;
    if (s_done_count !== base + 1 || s_cpu_hold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_done: pulses=%0d hold=%b expected 1 0", s_done_count - base, s_cpu_hold);
    end
    for (int i = 0; i < 4; i++) begin
      s_rd_en = 1; s_rd_addr = 2'(i);
      step;
      s_rd_en = 0;
      checks++;
      if (s_rd_data !== sm[i]) begin
        errors++;
        $display("[TB] FAIL wrap_mem[%0d]: got %h expected %h", i, s_rd_data, sm[i]);
      end
    end
  endtask

  task automatic test_bubbles_restart;
    load_start = 1;
    step;
    load_start = 0;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        load_valid = 0; load_data = 8'($urandom);
        step;
      end
      load_valid = 1; load_data = 8'($urandom); load_last = 0;
      step;
      model[i] = load_data;
    end
    load_valid = 0; load_start = 1;
    step;
    load_start = 0;
    checks++;
    if (load_ready !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_state: ready=%b done=%b expected 1 0", load_ready, load_done);
    end
    for (int i = 0; i < 2; i++) begin
      load_valid = 0; load_data = 8'($urandom);
      step;
      load_valid = 1; load_data = 8'($urandom); load_last = (i == 1);
      step;
      model[i] = load_data;
    end
    clear_inputs;
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_done: got %b expected 1", load_done);
    end
    step;
    for (int i = 0; i < 4; i++) begin
      cpu_read(8'(i));
      checks++;
      if (rd_data !== model[i]) begin
        errors++;
        $display("[TB] FAIL restart_mem[%0d]: got %h expected %h", i, rd_data, model[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] exp, ra, wa, wd;
    logic re, we;
    int n;
    for (int i = 0; i < 16; i++) cpu_write(8'(8'h80 + i), 8'($urandom));
    cpu_read(8'h80);
    exp = model[8'h80];
    for (int k = 0; k < 150; k++) begin
      re = 1'($urandom); we = 1'($urandom);
      ra = 8'(8'h80 + $urandom_range(0, 15));
      wa = 8'(8'h80 + $urandom_range(0, 15));
      wd = 8'($urandom);
      rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
      if (re) exp = model[ra];
      step;
      if (we) model[wa] = wd;
      checks++;
      if (rd_data !== exp) begin
        errors++;
        $display("[TB] FAIL random_cpu[%0d]: got %h expected %h", k, rd_data, exp);
      end
    end
    clear_inputs;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) load_buf[i] = 8'($urandom);
      run_load(n, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
        cpu_read(8'(i));
        checks++;
        if (rd_data !== model[i]) begin
          errors++;
          $display("[TB] FAIL random_load[%0d][%0d]: got %h expected %h", r, i, rd_data, model[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_then_read();
    test_write_read();
    test_cpu_blocked();
    test_reset_mid_load();
    test_wrap();
    test_bubbles_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
